// File: rtl/m4_pkg.sv
// Shared constants, commit-state encoding and reset-bank helper for the M4 colour-matrix stages.
package m4_pkg;

   localparam int unsigned COEF_W = 13;
   localparam int unsigned PIX_W  = 16;
   localparam int unsigned PROD_W = 31;
   localparam int unsigned CF_NUM = 9;

   localparam logic [COEF_W-1:0] CF_UNITY = 13'h0800;
   localparam logic [3:0]        CF_ADDR_LIM = 4'd9;

   localparam int unsigned CF_RR = 0;
   localparam int unsigned CF_GR = 1;
   localparam int unsigned CF_BR = 2;
   localparam int unsigned CF_RG = 3;
   localparam int unsigned CF_GG = 4;
   localparam int unsigned CF_BG = 5;
   localparam int unsigned CF_RB = 6;
   localparam int unsigned CF_GB = 7;
   localparam int unsigned CF_BB = 8;

   typedef logic [1:0] cstate_t;
   localparam cstate_t ST_IDLE  = 2'd0;
   localparam cstate_t ST_PEND  = 2'd1;
   localparam cstate_t ST_APPLY = 2'd2;

   function automatic logic [COEF_W-1:0] cf_reset(input int unsigned idx);
      return (idx == CF_RR || idx == CF_GG || idx == CF_BB) ? CF_UNITY : '0;
   endfunction

endpackage

// File: rtl/m4_smul16x13.sv
// One registered slice: unsigned 16b pixel times signed 13b coefficient, scaled so unity sits at bit 13.
module m4_smul16x13
   import m4_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PIX_W-1:0]         i_pix,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic [PROD_W-1:0]        o_prod
);

   logic signed [28:0] w_pix_x;
   logic signed [28:0] w_coef_x;
   logic signed [28:0] w_mul;

   assign w_pix_x  = 29'($signed({1'b0, i_pix}));
   assign w_coef_x = 29'(i_coef);
   assign w_mul    = w_pix_x * w_coef_x;

   always_ff @(posedge clk) begin
      if (rst) o_prod <= '0;
      else     o_prod <= {w_mul, 2'b00};
   end

endmodule

// File: rtl/m4_premult_xt2p5_a.sv
// XT2.5 M4 colour-matrix pre-multiply: 2-clk pipeline with frame-synchronous coefficient double-buffer.
// Optional active-bank readback port enabled by defining M4_COEF_RB_EN.
module m4_premult_xt2p5_a
   import m4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [PIX_W-1:0]  rin,
   input  logic [PIX_W-1:0]  gin,
   input  logic [PIX_W-1:0]  bin,
   input  logic              de_in,
   input  logic              vs,
   input  logic              cf_wr,
   input  logic [3:0]        cf_addr,
   input  logic [COEF_W-1:0] cf_wdata,
   input  logic              cf_commit,
   output logic              cf_pend,
   output logic [PROD_W-1:0] rr,
   output logic [PROD_W-1:0] gr,
   output logic [PROD_W-1:0] br,
   output logic [PROD_W-1:0] rg,
   output logic [PROD_W-1:0] gg,
   output logic [PROD_W-1:0] bg,
   output logic [PROD_W-1:0] rb,
   output logic [PROD_W-1:0] gb,
   output logic [PROD_W-1:0] bb,
   output logic [COEF_W-1:0] cf0d,
   output logic [COEF_W-1:0] cf4d,
   output logic [COEF_W-1:0] cf8d,
   output logic [PIX_W-1:0]  rdo,
   output logic [PIX_W-1:0]  gdo,
   output logic [PIX_W-1:0]  bdo,
`ifdef M4_COEF_RB_EN
   input  logic [3:0]        cf_raddr,
   output logic [COEF_W-1:0] cf_rdata,
`endif
   output logic              de_out
);

   cstate_t           r_state;
   cstate_t           w_state_nxt;
   logic              w_apply;
   logic [COEF_W-1:0] r_shadow  [CF_NUM];
   logic [COEF_W-1:0] r_active  [CF_NUM];
   logic [COEF_W-1:0] r_coef_s1 [CF_NUM];
   logic [PIX_W-1:0]  r_pix_s1  [3];
   logic              r_de_s1;
   logic [PROD_W-1:0] w_prod    [CF_NUM];

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (cf_commit) w_state_nxt = ST_PEND;
         ST_PEND:  if (vs) w_state_nxt = ST_APPLY;
         ST_APPLY: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_apply = (r_state == ST_APPLY);
   assign cf_pend = (r_state != ST_IDLE);

   // Active bank loads on the APPLY edge; the stage-1 snapshot taken on that same edge still sees
   // the old bank, so the switch lands cleanly between pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         for (int i = 0; i < CF_NUM; i++) begin
            r_shadow[i] <= cf_reset(i);
            r_active[i] <= cf_reset(i);
         end
      end else begin
         r_state <= w_state_nxt;
         if (cf_wr && (cf_addr < CF_ADDR_LIM)) r_shadow[cf_addr] <= cf_wdata;
         if (w_apply) r_active <= r_shadow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_de_s1 <= 1'b0;
         for (int i = 0; i < 3; i++) r_pix_s1[i] <= '0;
         for (int i = 0; i < CF_NUM; i++) r_coef_s1[i] <= cf_reset(i);
      end else begin
         r_de_s1     <= de_in;
         r_pix_s1[0] <= rin;
         r_pix_s1[1] <= gin;
         r_pix_s1[2] <= bin;
         r_coef_s1   <= r_active;
      end
   end

   for (genvar g = 0; g < CF_NUM; g++) begin : g_mul
      m4_smul16x13 u_mul (
         .clk    (clk),
         .rst    (rst),
         .i_pix  (r_pix_s1[g % 3]),
         .i_coef (r_coef_s1[g]),
         .o_prod (w_prod[g])
      );
   end

   assign rr = w_prod[CF_RR];
   assign gr = w_prod[CF_GR];
   assign br = w_prod[CF_BR];
   assign rg = w_prod[CF_RG];
   assign gg = w_prod[CF_GG];
   assign bg = w_prod[CF_BG];
   assign rb = w_prod[CF_RB];
   assign gb = w_prod[CF_GB];
   assign bb = w_prod[CF_BB];

   always_ff @(posedge clk) begin
      if (rst) begin
         de_out <= 1'b0;
         rdo    <= '0;
         gdo    <= '0;
         bdo    <= '0;
         cf0d   <= CF_UNITY;
         cf4d   <= CF_UNITY;
         cf8d   <= CF_UNITY;
      end else begin
         de_out <= r_de_s1;
         rdo    <= r_pix_s1[0];
         gdo    <= r_pix_s1[1];
         bdo    <= r_pix_s1[2];
         cf0d   <= r_coef_s1[CF_RR];
         cf4d   <= r_coef_s1[CF_GG];
         cf8d   <= r_coef_s1[CF_BB];
      end
   end

`ifdef M4_COEF_RB_EN
   always_ff @(posedge clk) begin
      if (rst)                          cf_rdata <= '0;
      else if (cf_raddr < CF_ADDR_LIM)  cf_rdata <= r_active[cf_raddr];
      else                              cf_rdata <= '0;
   end
`endif

endmodule

// File: tb/tb_m4_premult_xt2p5_a.sv
// Directed bench for m4_premult_xt2p5_a: vector table under the identity bank plus commit-timing sequences.
module tb_m4_premult_xt2p5_a;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rin, gin, bin;
   logic        de_in, vs, cf_wr, cf_commit, cf_pend;
   logic [3:0]  cf_addr;
   logic [12:0] cf_wdata;
   logic [30:0] rr, gr, br, rg, gg, bg, rb, gb, bb;
   logic [12:0] cf0d, cf4d, cf8d;
   logic [15:0] rdo, gdo, bdo;
   logic        de_out;
`ifdef M4_COEF_RB_EN
   logic [3:0]  cf_raddr = 4'd0;
   logic [12:0] cf_rdata;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   m4_premult_xt2p5_a dut (
      .clk       (clk),
      .rst       (rst),
      .rin       (rin),
      .gin       (gin),
      .bin       (bin),
      .de_in     (de_in),
      .vs        (vs),
      .cf_wr     (cf_wr),
      .cf_addr   (cf_addr),
      .cf_wdata  (cf_wdata),
      .cf_commit (cf_commit),
      .cf_pend   (cf_pend),
      .rr        (rr),
      .gr        (gr),
      .br        (br),
      .rg        (rg),
      .gg        (gg),
      .bg        (bg),
      .rb        (rb),
      .gb        (gb),
      .bb        (bb),
      .cf0d      (cf0d),
      .cf4d      (cf4d),
      .cf8d      (cf8d),
      .rdo       (rdo),
      .gdo       (gdo),
      .bdo       (bdo),
`ifdef M4_COEF_RB_EN
      .cf_raddr  (cf_raddr),
      .cf_rdata  (cf_rdata),
`endif
      .de_out    (de_out)
   );

   logic [30:0] w_p [9];
   assign w_p = '{rr, gr, br, rg, gg, bg, rb, gb, bb};

   typedef struct {
      logic [15:0] r, g, b;
      logic [30:0] exp [9];
   } vec_t;

   function automatic vec_t mk(input logic [15:0] r, g, b, input logic [30:0] err, egg, ebb);
      vec_t v;
      v.r = r; v.g = g; v.b = b;
      for (int i = 0; i < 9; i++) v.exp[i] = '0;
      v.exp[0] = err; v.exp[4] = egg; v.exp[8] = ebb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix2(input logic [15:0] r, g, b);
      rin = r; gin = g; bin = b; de_in = 1'b1;
      tick();
      tick();
   endtask

   task automatic wr(input logic [3:0] a, input logic [12:0] d);
      cf_wr = 1'b1; cf_addr = a; cf_wdata = d;
      tick();
      cf_wr = 1'b0;
   endtask

   task automatic commit_apply();
      cf_commit = 1'b1;
      tick();
      cf_commit = 1'b0;
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
   endtask

   vec_t tbl [4];

   initial begin
      tbl[0] = mk(16'h1234, 16'h0000, 16'h0000, 31'h02468000, 31'h0, 31'h0);
      tbl[1] = mk(16'h0000, 16'hFFFF, 16'h0000, 31'h0, 31'h1FFFE000, 31'h0);
      tbl[2] = mk(16'h0001, 16'h0002, 16'h0003, 31'h00002000, 31'h00004000, 31'h00006000);
      tbl[3] = mk(16'h8000, 16'h4000, 16'hFFFF, 31'h10000000, 31'h08000000, 31'h1FFFE000);

      rst = 1'b1; rin = 16'h1234; gin = '0; bin = '0; de_in = 1'b1; vs = 1'b0;
      cf_wr = 1'b0; cf_addr = '0; cf_wdata = '0; cf_commit = 1'b0;
      tick(); tick(); tick();
      chk("rst_rr", 32'(rr), 32'h0);
      chk("rst_de_out", 32'(de_out), 32'h0);
      chk("rst_pend", 32'(cf_pend), 32'h0);
      chk("rst_cf0d", 32'(cf0d), 32'h0800);
      chk("rst_rdo", 32'(rdo), 32'h0);

      // Reset defaults: first valid output two clocks after release
      rst = 1'b0;
      tick();
      chk("lat_de_1clk", 32'(de_out), 32'h0);
      tick();
      chk("t1_rr", 32'(rr), 32'h02468000);
      chk("t1_gr", 32'(gr), 32'h0);
      chk("t1_de_out", 32'(de_out), 32'h1);
      chk("t1_rdo", 32'(rdo), 32'h1234);

      for (int t = 0; t < 4; t++) begin
         pix2(tbl[t].r, tbl[t].g, tbl[t].b);
         for (int k = 0; k < 9; k++)
            chk($sformatf("vec%0d_p%0d", t, k), 32'(w_p[k]), 32'(tbl[t].exp[k]));
         chk($sformatf("vec%0d_gdo", t), 32'(gdo), 32'(tbl[t].g));
         chk($sformatf("vec%0d_bdo", t), 32'(bdo), 32'(tbl[t].b));
      end

      // Negative coefficient on G->R
      wr(4'd1, 13'h1800);
      cf_commit = 1'b1;
      tick();
      cf_commit = 1'b0;
      chk("t2_pend_set", 32'(cf_pend), 32'h1);
      vs = 1'b1;
      tick();
      vs = 1'b0;
      chk("t2_pend_apply", 32'(cf_pend), 32'h1);
      tick();
      chk("t2_pend_clr", 32'(cf_pend), 32'h0);
      pix2(16'h0000, 16'h0100, 16'h0000);
      chk("t2_gr", 32'(gr), 32'h7FE00000);
      chk("t2_gg", 32'(gg), 32'h00200000);

      // Max-magnitude coefficients
      wr(4'd0, 13'h0FFF);
      commit_apply();
      pix2(16'hFFFF, 16'h0000, 16'h0000);
      chk("t3_rr_pos", 32'(rr), 32'h3FFBC004);
      chk("t3_cf0d_pos", 32'(cf0d), 32'h0FFF);
      wr(4'd0, 13'h1000);
      commit_apply();
      pix2(16'hFFFF, 16'h0000, 16'h0000);
      chk("t3_rr_neg", 32'(rr), 32'h40004000);

      // Commit held off without vs for 100 clocks
      wr(4'd0, 13'h0800);
      cf_commit = 1'b1;
      rin = 16'h0001;
      tick();
      cf_commit = 1'b0;
      for (int c = 0; c < 100; c++) tick();
      chk("t4_rr_old", 32'(rr), 32'h7FFFC000);
      chk("t4_pend_hold", 32'(cf_pend), 32'h1);
      rin = 16'h0003; vs = 1'b1;
      tick();
      vs = 1'b0; rin = 16'h0005;
      chk("t4_pend_after_vs", 32'(cf_pend), 32'h1);
      tick();
      chk("t4_pend_drop", 32'(cf_pend), 32'h0);
      chk("t4_rr_vs_pix", 32'(rr), 32'h7FFF4000);
      rin = 16'h0007;
      tick();
      chk("t4_rr_apply_pix", 32'(rr), 32'h7FFEC000);
      chk("t4_cf0d_old", 32'(cf0d), 32'h1000);
      tick();
      chk("t4_rr_new", 32'(rr), 32'h0000E000);
      chk("t4_cf0d_new", 32'(cf0d), 32'h0800);

      // Commit and vs together: wait for the next vs; addr 12 write ignored
      wr(4'd1, 13'h0000);
      cf_commit = 1'b1; vs = 1'b1;
      tick();
      cf_commit = 1'b0; vs = 1'b0;
      chk("t5_pend", 32'(cf_pend), 32'h1);
      wr(4'd12, 13'h0123);
      pix2(16'h0000, 16'h0100, 16'h0000);
      chk("t5_gr_old", 32'(gr), 32'h7FE00000);
      chk("t5_pend_wait", 32'(cf_pend), 32'h1);
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
      chk("t5_pend_clr", 32'(cf_pend), 32'h0);
      pix2(16'h0000, 16'h0100, 16'h0000);
      chk("t5_gr_new", 32'(gr), 32'h0);
      chk("t5_gg", 32'(gg), 32'h00200000);
      chk("t5_cf4d", 32'(cf4d), 32'h0800);

      // Reset during PEND
      wr(4'd4, 13'h0400);
      cf_commit = 1'b1;
      tick();
      cf_commit = 1'b0;
      chk("t6_pend", 32'(cf_pend), 32'h1);
      rst = 1'b1;
      tick();
      chk("t6_rst_pend", 32'(cf_pend), 32'h0);
      chk("t6_rst_de", 32'(de_out), 32'h0);
      chk("t6_rst_gg", 32'(gg), 32'h0);
      rst = 1'b0;
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
      chk("t6_pend_after_vs", 32'(cf_pend), 32'h0);
      pix2(16'h0000, 16'h0100, 16'h0000);
      chk("t6_gg_identity", 32'(gg), 32'h00200000);
      chk("t6_cf4d", 32'(cf4d), 32'h0800);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
